// File: rtl/spi_master.sv
// spi_master: single-clock SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Parallel side: valid/ready word in, one-cycle rx_valid pulse out.
// Optional burst mode is built when SPI_MASTER_BURST_EN is defined. In that
// mode a new word offered on the final sclk fall continues the transfer with
// cs held low. Without the macro, every frame runs SETUP..HOLD and cs is
// deasserted between frames.
module spi_master #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  // One shared counter serves setup, half-period and hold timing.
  localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              busy_q;
  logic              sclk_q;
  logic              cs_q;
  logic              last_fall_s;

  // The cycle before the final sclk fall of a frame; this is the burst acceptance slot.
  assign last_fall_s = (state_q == SHIFT) && sclk_q &&
                       (cnt_q == CNT_W'(CLK_DIV - 1)) &&
                       (bit_cnt_q == BIT_W'(DATA_W));

  assign tx_ready = (state_q == IDLE) || (BURST_EN && last_fall_s);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;
  // The MSB of the transmit shifter is the mosi flop itself.
  assign mosi     = tx_sh_q[DATA_W-1];

  // Frame sequencer: the state, the timing counters, the shifters and all registered SPI outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            tx_sh_q   <= tx_data;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cnt_q != CNT_W'(CLK_DIV - 1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              // Rising edge: capture miso as it stands on this clk edge.
              rx_sh_q   <= {rx_sh_q[DATA_W-2:0], miso};
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end else if (bit_cnt_q != BIT_W'(DATA_W)) begin
              // Falling edge mid-frame: present the next bit.
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end else if (BURST_EN && tx_valid) begin
              // Final fall with a new word waiting: restart shifting with cs held low.
              tx_sh_q    <= tx_data;
              bit_cnt_q  <= '0;
              rx_data_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
            end else begin
              // Final fall: mosi keeps the last bit through HOLD.
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
            cnt_q      <= '0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
